addr_seq_gen: RTL and testbench

ADDR_SEQ_GEN -- requirements
Module: addr_seq_gen

---
 rtl/addr_seq_pkg.sv | 11 +
 rtl/addr_seq_gen_if.sv | 32 +++
 rtl/addr_seq_step.sv | 32 +++
 rtl/addr_seq_gen.sv | 134 +++++++++++++
 tb/tb_addr_seq_gen.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/addr_seq_pkg.sv
// Shared types and constants for the address sequence generator.
package addr_seq_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  localparam int unsigned WC_W = 8;

endpackage

// File: rtl/addr_seq_gen_if.sv
// Control/status bundle of addr_seq_gen; slave is the generator, master its driver.
import addr_seq_pkg::*;

interface addr_seq_gen_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned STEP_W = 4
);
  logic              start;
  logic              abort;
  logic              enable;
  logic              dir_down;
  logic              wrap_mode;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] limit;
  logic [STEP_W-1:0] step;
  logic [ADDR_W-1:0] addr;
  logic              tc;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic [WC_W-1:0]   wrap_cnt;

  modport slave (
    input  start, abort, enable, dir_down, wrap_mode, base, limit, step,
    output addr, tc, busy, done, cfg_err, wrap_cnt
  );

  modport master (
    output start, abort, enable, dir_down, wrap_mode, base, limit, step,
    input  addr, tc, busy, done, cfg_err, wrap_cnt
  );
endinterface

// File: rtl/addr_seq_step.sv
// Next-address and end-of-pass computation; one extra bit catches range overflow/underflow.
module addr_seq_step #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned STEP_W = 4
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              dir_down_i,
  input  logic [ADDR_W-1:0] limit_i,
  output logic [ADDR_W-1:0] next_o,
  output logic              end_o
);
  logic [STEP_W-1:0] step_eff;
  logic [ADDR_W:0]   step_ext;
  logic [ADDR_W:0]   sum;
  logic [ADDR_W:0]   diff;

  always_comb begin
    step_eff = (step_i == '0) ? STEP_W'(1) : step_i;
    step_ext = {{(ADDR_W + 1 - STEP_W){1'b0}}, step_eff};
    sum      = {1'b0, addr_i} + step_ext;
    diff     = {1'b0, addr_i} - step_ext;
    if (dir_down_i) begin
      next_o = diff[ADDR_W-1:0];
      // Borrow out of the top bit means the step ran below zero.
      end_o  = (addr_i == limit_i) || diff[ADDR_W] || (diff[ADDR_W-1:0] < limit_i);
    end else begin
      next_o = sum[ADDR_W-1:0];
      end_o  = (addr_i == limit_i) || (sum > {1'b0, limit_i});
    end
  end
endmodule

// File: rtl/addr_seq_gen.sv
// Programmable up/down address sequencer with stop/wrap end-of-pass handling.
// Define ADDR_SEQ_WRAP_CNT_EN to build the completed-pass counter on wrap_cnt.
import addr_seq_pkg::*;

module addr_seq_gen #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned STEP_W = 4
) (
  input  logic            clock,
  input  logic            reset,
  addr_seq_gen_if.slave   bus
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;
  logic              dir_q, dir_d;
  logic              wrap_q, wrap_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] limit_q, limit_d;
  logic [STEP_W-1:0] step_q, step_d;

  logic [ADDR_W-1:0] next_addr;
  logic              end_pass;
  logic              cfg_legal;

  addr_seq_step #(
    .ADDR_W (ADDR_W),
    .STEP_W (STEP_W)
  ) u_step (
    .addr_i     (addr_q),
    .step_i     (step_q),
    .dir_down_i (dir_q),
    .limit_i    (limit_q),
    .next_o     (next_addr),
    .end_o      (end_pass)
  );

  assign cfg_legal = bus.dir_down ? (bus.base >= bus.limit) : (bus.base <= bus.limit);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    cfg_err_d = cfg_err_q;
    dir_d     = dir_q;
    wrap_d    = wrap_q;
    base_d    = base_q;
    limit_d   = limit_q;
    step_d    = step_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (bus.start) begin
        if (cfg_legal) begin
          state_d   = RUN;
          addr_d    = bus.base;
          cfg_err_d = 1'b0;
          dir_d     = bus.dir_down;
          wrap_d    = bus.wrap_mode;
          base_d    = bus.base;
          limit_d   = bus.limit;
          step_d    = bus.step;
        end else begin
          cfg_err_d = 1'b1;
        end
      end
    end else if (bus.enable) begin
      if (end_pass) begin
        if (wrap_q) begin
          addr_d = base_q;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end else begin
        addr_d = next_addr;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      dir_q     <= 1'b0;
      wrap_q    <= 1'b0;
      base_q    <= '0;
      limit_q   <= '0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      dir_q     <= dir_d;
      wrap_q    <= wrap_d;
      base_q    <= base_d;
      limit_q   <= limit_d;
      step_q    <= step_d;
    end
  end

  assign bus.addr    = addr_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.tc      = (state_q == RUN) && end_pass;
  assign bus.done    = done_q;
  assign bus.cfg_err = cfg_err_q;

`ifdef ADDR_SEQ_WRAP_CNT_EN
  logic [WC_W-1:0] wrap_cnt_q;
  logic            start_ok;
  logic            pass_end;

  assign start_ok = (state_q == IDLE) && bus.start && !bus.abort && cfg_legal;
  assign pass_end = (state_q == RUN) && bus.enable && !bus.abort && end_pass;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrap_cnt_q <= '0;
    end else if (start_ok) begin
      wrap_cnt_q <= '0;
    end else if (pass_end && (wrap_cnt_q != '1)) begin
      wrap_cnt_q <= wrap_cnt_q + 1'b1;
    end
  end

  assign bus.wrap_cnt = wrap_cnt_q;
`else
  assign bus.wrap_cnt = '0;
`endif
endmodule

// File: tb/tb_addr_seq_gen.sv
// Directed bench for addr_seq_gen: vector table plus multi-cycle corner sequences.
module tb_addr_seq_gen;
`ifdef ADDR_SEQ_WRAP_CNT_EN
  localparam bit WC_EN = 1'b1;
`else
  localparam bit WC_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  addr_seq_gen_if #(.ADDR_W(12), .STEP_W(4)) bus ();

  addr_seq_gen #(.ADDR_W(12), .STEP_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       start, abort, en, dn, wrap;
    logic [11:0] base, limit;
    logic [3:0]  step;
    logic [11:0] e_addr;
    logic        e_tc, e_busy, e_done, e_err;
    logic [7:0]  e_wc;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic st, ab, en, dn, wr,
                              input logic [11:0] b, l, input logic [3:0] s,
                              input logic [11:0] ea, input logic et, eb, ed, ee,
                              input logic [7:0] ew);
    vec_t v;
    v.start = st; v.abort = ab; v.en = en; v.dn = dn; v.wrap = wr;
    v.base = b; v.limit = l; v.step = s;
    v.e_addr = ea; v.e_tc = et; v.e_busy = eb; v.e_done = ed; v.e_err = ee;
    v.e_wc = WC_EN ? ew : 8'd0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, ab, en, dn, wr,
                       input logic [11:0] b, l, input logic [3:0] s);
    bus.start = st; bus.abort = ab; bus.enable = en; bus.dir_down = dn;
    bus.wrap_mode = wr; bus.base = b; bus.limit = l; bus.step = s;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [11:0] ea, input logic et, eb, ed, ee,
                         input logic [7:0] ew);
    chk({tag, ".addr"}, 32'(bus.addr), 32'(ea));
    chk({tag, ".tc"}, 32'(bus.tc), 32'(et));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(eb));
    chk({tag, ".done"}, 32'(bus.done), 32'(ed));
    chk({tag, ".cfg_err"}, 32'(bus.cfg_err), 32'(ee));
    chk({tag, ".wrap_cnt"}, 32'(bus.wrap_cnt), 32'(WC_EN ? ew : 8'd0));
  endtask

  initial begin
    //            st ab en dn wr base    limit   step  addr    tc bsy dn err wc
    vecs[0]  = mk(1, 0, 1, 0, 1, 12'h010, 12'h01A, 4'd4, 12'h010, 0, 1, 0, 0, 0);
    vecs[1]  = mk(0, 0, 1, 0, 0, 12'h000, 12'h000, 4'd0, 12'h014, 0, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 0, 0, 12'h000, 12'h000, 4'd0, 12'h018, 1, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 0, 0, 12'h000, 12'h000, 4'd0, 12'h010, 0, 1, 0, 0, 1);
    vecs[4]  = mk(0, 1, 1, 0, 0, 12'h000, 12'h000, 4'd0, 12'h010, 0, 0, 0, 0, 1);
    vecs[5]  = mk(1, 0, 1, 1, 0, 12'h020, 12'h010, 4'd8, 12'h020, 0, 1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 1, 0, 0, 12'h000, 12'h000, 4'd0, 12'h018, 0, 1, 0, 0, 0);
    vecs[7]  = mk(0, 0, 1, 0, 0, 12'h000, 12'h000, 4'd0, 12'h010, 1, 1, 0, 0, 0);
    vecs[8]  = mk(0, 0, 1, 0, 0, 12'h000, 12'h000, 4'd0, 12'h010, 0, 0, 1, 0, 1);
    vecs[9]  = mk(0, 0, 1, 0, 0, 12'h000, 12'h000, 4'd0, 12'h010, 0, 0, 0, 0, 1);
    vecs[10] = mk(1, 0, 1, 0, 0, 12'h100, 12'h0FF, 4'd1, 12'h010, 0, 0, 0, 1, 1);
    vecs[11] = mk(0, 0, 1, 0, 0, 12'h000, 12'h000, 4'd0, 12'h010, 0, 0, 0, 1, 1);
    vecs[12] = mk(1, 0, 0, 0, 0, 12'h005, 12'h005, 4'd0, 12'h005, 1, 1, 0, 0, 0);
    vecs[13] = mk(0, 0, 1, 0, 0, 12'h000, 12'h000, 4'd0, 12'h005, 0, 0, 1, 0, 1);
    vecs[14] = mk(1, 0, 0, 0, 0, 12'hFF0, 12'hFFF, 4'hF, 12'hFF0, 0, 1, 0, 0, 0);
    vecs[15] = mk(0, 0, 1, 0, 0, 12'h000, 12'h000, 4'd0, 12'hFFF, 1, 1, 0, 0, 0);
    vecs[16] = mk(1, 0, 0, 1, 1, 12'h123, 12'h000, 4'd2, 12'hFFF, 1, 1, 0, 0, 0);
    vecs[17] = mk(0, 0, 1, 0, 0, 12'h000, 12'h000, 4'd0, 12'hFFF, 0, 0, 1, 0, 1);
    vecs[18] = mk(1, 0, 0, 0, 0, 12'hFF8, 12'hFFF, 4'hF, 12'hFF8, 1, 1, 0, 0, 0);
    vecs[19] = mk(0, 0, 1, 0, 0, 12'h000, 12'h000, 4'd0, 12'hFF8, 0, 0, 1, 0, 1);
    vecs[20] = mk(1, 0, 0, 1, 0, 12'h003, 12'h000, 4'd8, 12'h003, 1, 1, 0, 0, 0);
    vecs[21] = mk(0, 0, 1, 0, 0, 12'h000, 12'h000, 4'd0, 12'h003, 0, 0, 1, 0, 1);

    drive(0, 0, 0, 0, 0, 12'h0, 12'h0, 4'd0);
    #2;
    chk_all("reset", 12'h000, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].start, vecs[i].abort, vecs[i].en, vecs[i].dn, vecs[i].wrap,
            vecs[i].base, vecs[i].limit, vecs[i].step);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_tc, vecs[i].e_busy,
              vecs[i].e_done, vecs[i].e_err, vecs[i].e_wc);
    end

    // Full-range up count, stop mode.
    drive(1, 0, 1, 0, 0, 12'h000, 12'hFFF, 4'd1);
    tick();
    chk_all("full.start", 12'h000, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 12'h000, 12'h000, 4'd0);
    for (int i = 1; i < 4096; i++) begin
      tick();
      chk("full.addr", 32'(bus.addr), 32'(i));
      chk("full.tc", 32'(bus.tc), 32'(i == 4095));
    end
    tick();
    chk_all("full.end", 12'hFFF, 0, 0, 1, 0, 1);
    tick();
    chk_all("full.hold", 12'hFFF, 0, 0, 0, 0, 1);

    // Enable low mid-run, then abort coinciding with end of pass.
    drive(1, 0, 1, 0, 0, 12'h010, 12'h01A, 4'd4);
    tick();
    drive(0, 0, 1, 0, 0, 12'h000, 12'h000, 4'd0);
    tick();
    tick();
    chk_all("hold.tc", 12'h018, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 12'h000, 12'h000, 4'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all($sformatf("hold%0d", i), 12'h018, 1, 1, 0, 0, 0);
    end
    drive(1, 1, 1, 0, 0, 12'h000, 12'hFFF, 4'd1);
    tick();
    chk_all("abort", 12'h018, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 12'h000, 12'h000, 4'd0);
    tick();
    chk_all("abort.after", 12'h018, 0, 0, 0, 0, 0);

    // Asynchronous reset between edges, then no resume after release.
    drive(1, 0, 1, 0, 1, 12'h100, 12'h200, 4'd3);
    tick();
    drive(0, 0, 1, 0, 0, 12'h000, 12'h000, 4'd0);
    tick();
    chk("areset.pre", 32'(bus.addr), 32'h103);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk_all("areset", 12'h000, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    tick();
    chk_all("areset.noresume", 12'h000, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
